// File: rtl/fetch_queue_pkg.sv
// Shared core parameters for the instruction fetch front end.
package fetch_queue_pkg;
  localparam int          CORE_DATA_WIDTH = 32;
  localparam int          CORE_ADDR_WIDTH = 8;
  localparam int          CORE_FQ_DEPTH   = 4;
  localparam logic [31:0] CORE_RESET_PC   = 32'h0000_0000;
endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read port.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word fetches, buffers {instr, pc} entries, flushes on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = CORE_FQ_DEPTH,
  parameter int DATA_WIDTH = CORE_DATA_WIDTH,
  parameter int ADDR_WIDTH = CORE_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [31:0]           o_pc,
  input  logic                  i_ready,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 32;

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc, r_req_pc;
  logic          r_inflight;

  logic          w_issue, w_push, w_pop;
  logic [31:0]   w_fetch_pc;
  logic [EW-1:0] w_rd;

  assign w_fetch_pc = i_redirect ? i_redirect_pc : r_pc;
  // Credit check counts the outstanding response but never the same-cycle pop.
  assign w_issue    = i_redirect || ((r_count + CW'(r_inflight)) < CW'(DEPTH));
  assign w_pop      = (r_count != '0) && i_ready;
  // r_inflight gates out stray responses, e.g. the one right after reset release.
  assign w_push     = i_mem_valid && r_inflight && !i_redirect;

  assign o_mem_req  = i_rst_n && w_issue;
  assign o_mem_addr = w_fetch_pc[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pc       <= CORE_RESET_PC;
      r_req_pc   <= CORE_RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_fetch_pc;
        r_pc     <= w_fetch_pc + 32'd1;
      end
      if (i_redirect) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_pop)  r_head <= r_head + PW'(1);
        if (w_push) r_tail <= r_tail + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  fq_storage #(.DEPTH(DEPTH), .WIDTH(EW)) u_storage (
    .i_clk   (i_clk),
    .i_we    (w_push && i_rst_n),
    .i_waddr (r_tail),
    .i_wdata ({i_mem_data, r_req_pc}),
    .i_raddr (r_head),
    .o_rdata (w_rd)
  );

  // Masking with o_valid keeps outputs at zero while empty or in reset.
  assign o_valid = (r_count != '0);
  assign o_instr = o_valid ? w_rd[EW-1:32] : '0;
  assign o_pc    = o_valid ? w_rd[31:0]    : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model plus directed literal checkpoints.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, mem_valid, ready, redirect;
  logic [31:0] mem_data, redirect_pc;
  logic        mem_req, valid;
  logic [7:0]  mem_addr;
  logic [31:0] instr, pc;

  fetch_queue dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_valid(mem_valid), .i_mem_data(mem_data), .o_valid(valid), .o_instr(instr),
    .o_pc(pc), .i_ready(ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the queue contents and the next expected fetch address.
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc = 0, m_reqpc = 0;
  bit          m_rsp_due = 0;

  task automatic model_step();
    bit          iss;
    logic [31:0] fpc;
    if (!rst_n) begin
      m_q.delete(); m_pc = 0; m_reqpc = 0; m_rsp_due = 0;
    end else begin
      iss = redirect || (m_q.size() + int'(m_rsp_due) < DEPTH);
      fpc = redirect ? redirect_pc : m_pc;
      if (redirect) m_q.delete();
      else begin
        if (ready && m_q.size() != 0) void'(m_q.pop_front());
        if (mem_valid && m_rsp_due) m_q.push_back('{mem_data, m_reqpc});
      end
      if (iss) begin m_reqpc = fpc; m_pc = fpc + 32'd1; end
      m_rsp_due = iss;
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ea;
      ea = redirect ? redirect_pc : m_pc;
      chk("o_valid", {31'h0, valid}, {31'h0, m_q.size() != 0});
      chk("o_instr", instr, m_q.size() != 0 ? m_q[0].d : 32'h0);
      chk("o_pc", pc, m_q.size() != 0 ? m_q[0].pc : 32'h0);
      chk("o_mem_req", {31'h0, mem_req},
          {31'h0, rst_n && (redirect || (m_q.size() + int'(m_rsp_due) < DEPTH))});
      chk("o_mem_addr", {24'h0, mem_addr}, ea & 32'hFF);
    end
  end

  // One clock: memory answers last cycle's request with mem[a] = a + 0x100.
  task automatic tick();
    logic       r;
    logic [7:0] a;
    @(negedge clk); r = mem_req; a = mem_addr;
    @(posedge clk); model_step();
    #1; mem_valid = r; mem_data = 32'h100 + {24'h0, a};
  endtask

  // Release reset; the stray response in the release cycle must be dropped.
  task automatic release_rst();
    tick(); rst_n = 1; mem_valid = 1; mem_data = 32'hDEAD_BEEF;
  endtask

  task automatic hold_rst();
    tick(); rst_n = 0; tick();
  endtask

  int thr;
  bit prev_rst;

  initial begin
    rst_n = 0; ready = 1; redirect = 0; redirect_pc = 0; mem_valid = 0; mem_data = 0;
    tick(); chk_en = 1; tick();
    #2 chk("rst o_valid", {31'h0, valid}, 0); chk("rst o_mem_req", {31'h0, mem_req}, 0);
    chk("rst o_pc", pc, 0); chk("rst o_instr", instr, 0);

    // Sequential stream after reset
    release_rst();
    #2 chk("c0 req", {31'h0, mem_req}, 1); chk("c0 addr", {24'h0, mem_addr}, 0);
    tick(); #2 chk("c1 valid", {31'h0, valid}, 0); chk("c1 addr", {24'h0, mem_addr}, 1);
    tick(); #2 chk("c2 pc", pc, 0); chk("c2 instr", instr, 32'h100);
    tick(); #2 chk("c3 pc", pc, 1); chk("c3 instr", instr, 32'h101);
    tick(); #2 chk("c4 pc", pc, 2); chk("c4 instr", instr, 32'h102);

    // Stall fills the queue, then drains in order with no pop credit
    hold_rst(); release_rst(); ready = 0;
    for (int c = 1; c < 10; c++) begin
      tick();
      if (c == 4) #2 chk("stall c4 req", {31'h0, mem_req}, 0);
    end
    #2 chk("stall c9 req", {31'h0, mem_req}, 0); chk("stall c9 pc", pc, 0);
    tick(); ready = 1;
    #2 chk("drain c10 pc", pc, 0); chk("drain c10 req", {31'h0, mem_req}, 0);
    for (int c = 1; c < 5; c++) begin
      tick(); #2 chk("drain pc", pc, c);
    end

    // Redirect while credit-full with a response in flight
    hold_rst(); release_rst(); ready = 0;
    for (int c = 1; c < 4; c++) tick();
    tick(); redirect = 1; redirect_pc = 32'h40;
    #2 chk("rd addr", {24'h0, mem_addr}, 32'h40); chk("rd req", {31'h0, mem_req}, 1);
    tick(); redirect = 0; #2 chk("rd+1 valid", {31'h0, valid}, 0);
    tick(); #2 chk("rd+2 pc", pc, 32'h40); chk("rd+2 instr", instr, 32'h140);

    // Redirect coincident with pop and push
    ready = 1;
    repeat (6) tick();
    tick(); redirect = 1; redirect_pc = 32'h80;
    tick(); redirect = 0; #2 chk("rpp valid", {31'h0, valid}, 0); chk("rpp addr", {24'h0, mem_addr}, 32'h81);

    // Back-to-back redirects
    tick(); redirect = 1; redirect_pc = 32'h10;
    tick(); redirect_pc = 32'h20;
    tick(); redirect = 0; #2 chk("b2b valid", {31'h0, valid}, 0);
    tick(); #2 chk("b2b pc0", pc, 32'h20); chk("b2b instr", instr, 32'h120);
    tick(); #2 chk("b2b pc1", pc, 32'h21);

    // PC wrap
    tick(); redirect = 1; redirect_pc = 32'hFFFF_FFFF; #2 chk("wrap addr0", {24'h0, mem_addr}, 32'hFF);
    tick(); redirect = 0; #2 chk("wrap addr1", {24'h0, mem_addr}, 0);
    tick(); #2 chk("wrap pc0", pc, 32'hFFFF_FFFF); chk("wrap instr", instr, 32'h1FF);
    tick(); #2 chk("wrap pc1", pc, 0); chk("wrap instr1", instr, 32'h100);

    // Mid-stream reset
    tick(); rst_n = 0;
    tick(); #2 chk("mrst valid", {31'h0, valid}, 0); chk("mrst req", {31'h0, mem_req}, 0);
    chk("mrst pc", pc, 0); chk("mrst instr", instr, 0);
    release_rst();
    tick(); #2 chk("mrst c1 valid", {31'h0, valid}, 0);
    tick(); #2 chk("mrst c2 pc", pc, 0); chk("mrst c2 instr", instr, 32'h100);

    // Randomized traffic against the model
    thr = 50; prev_rst = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i % 256 == 0) thr = ($urandom % 3 == 0) ? 10 : (($urandom % 2 == 0) ? 50 : 95);
      ready = ($urandom % 100) < thr;
      redirect = ($urandom % 20) == 0;
      redirect_pc = ($urandom % 3 == 0) ? 32'hFFFF_FFFF - ($urandom % 4) : $urandom;
      rst_n = ($urandom % 300) != 0;
      if (rst_n && !prev_rst) begin mem_valid = 1; mem_data = $urandom; end
      prev_rst = rst_n;
    end
    tick(); chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
